fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// holds the returned word for decode, and restarts on branch/jump redirects.
// Responses for requests abandoned by redirect or reset are discarded.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [2:0]  if_imm_type
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrain
    } state_t;

    state_t      state;
    logic [31:0] pc;
    // Responses still owed by memory for requests abandoned across a reset.
    logic [1:0]  drop;
    logic [1:0]  drop_pend;
    logic        rsp;

    assign imem_req  = (state == StReq) && !redirect && !rst && (!if_valid || !stall);
    assign imem_addr = pc;

    // A response belongs to the current request only once older abandoned ones are drained.
    assign rsp       = imem_rvalid && (drop == 2'd0);
    // In WAIT/DRAIN one request is in flight; reset turns it into one to drop.
    assign drop_pend = drop + {1'b0, state != StReq};

    // Fetch control: pc, request state, held instruction and stale-response bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            state    <= StReq;
            if_valid <= 1'b0;
            if_inst  <= 32'h0000_0013;
            if_pc    <= 32'h0000_0000;
            drop     <= drop_pend - {1'b0, imem_rvalid && (drop_pend != 2'd0)};
        end else begin
            if (imem_rvalid && (drop != 2'd0)) begin
                drop <= drop - 2'd1;
            end
            // Decode takes the held instruction; a same-cycle load below overrides.
            if (if_valid && !stall) begin
                if_valid <= 1'b0;
            end
            if (redirect) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                if_valid <= 1'b0;
                // A response landing with the redirect is the one being waited for, so
                // there is nothing left to drain; this also keeps DRAIN from waiting forever.
                state    <= ((state != StReq) && !rsp) ? StDrain : StReq;
            end else begin
                unique case (state)
                    StReq: begin
                        if (imem_req) begin
                            state <= StWait;
                        end
                    end
                    StWait: begin
                        if (rsp) begin
                            if_inst  <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                            state    <= StReq;
                        end
                    end
                    StDrain: begin
                        if (rsp) begin
                            state <= StReq;
                        end
                    end
                    default: state <= StReq;
                endcase
            end
        end
    end

    // Immediate format for the held instruction, keyed on the major opcode.
    always_comb begin
        if_imm_type = 3'b001;
        case (if_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: if_imm_type = 3'b000;
            7'b0100011:                         if_imm_type = 3'b010;
            7'b1100011:                         if_imm_type = 3'b011;
            7'b0110111, 7'b0010111:             if_imm_type = 3'b100;
            7'b1101111:                         if_imm_type = 3'b101;
            default:                            if_imm_type = 3'b001;
        endcase
    end

endmodule
